text_console_writer: RTL and testbench
======================================

Name: text_console_writer

Overview:
- Writer side of the text RAM write port (ram_ce/ram_addr/ram_data) scanned by the LCD text display.
- Accepts a character byte stream from the MCU bus (valid/ready) and writes {attr, char} cells at a hardware cursor.
- Handles control codes, line wrap and screen clear, so software can print with plain byte writes.
- Sits in the clk_sys domain; its outputs drive the RAM's write clock domain directly.

Parameters:
- COLS, 100, characters per line (800 px / 8).
- ROWS, 30, lines per page (480 px / 16).
- ADDR_W, 12, text RAM address width.
- TAB_W, 8, tab stop spacing in columns.
- CLEAR_ON_RESET, 1, perform a full clear after reset release.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  character byte offered.
- in_ready  out  1  block can accept a byte this cycle.
- in_char  in  8  character or control code.
- in_attr  in  8  colour attribute, sampled with the byte: fg in [7:4], bg in [3:0].
- cur_set  in  1  one-cycle pulse: load cursor from cur_x_in/cur_y_in.
- cur_x_in  in  7  requested column.
- cur_y_in  in  5  requested row.
- cursor_x  out  7  current column.
- cursor_y  out  5  current row.
- busy  out  1  clear operation in progress.
- ram_ce  out  1  text RAM write strobe, one cell per cycle.
- ram_addr  out  ADDR_W  cell address = row*COLS + col.
- ram_data  out  16  {attr[7:0], char[7:0]}.

Behaviour:
- Reset values: ram_ce=0, ram_addr=0, ram_data=0, cursor=(0,0), in_ready=0, busy=0, state=IDLE.
- After reset release: with CLEAR_ON_RESET=1, enter CLR_ALL using attr 0x0F; otherwise enter IDLE.
- States: IDLE, CLR_ROW, CLR_ALL.
- in_ready = (state==IDLE) && !cur_set. Combinational.
- A byte is accepted when in_valid && in_ready. All RAM outputs are registered, so any write appears one cycle after acceptance.
- Printable byte (0x20–0x7E, 0x80–0xFF): write {in_attr, in_char} at the cursor, then advance the column.
- 0x0D (CR): col=0. No write.
- 0x0A (LF): row+1, col unchanged. No write.
- 0x08 (BS): if col>0, col-1; at col 0, no change. No write.
- 0x09 (TAB): col advances to the next multiple of TAB_W. If the result is ≥COLS, perform a line wrap.
- 0x0C (FF): go to CLR_ALL with in_attr; cursor homes to (0,0) at the end of the clear.
- Other control codes: consumed and ignored.
- Line wrap: col reaching COLS sets col=0 and row+1.
- Row overflow: row leaving ROWS-1 wraps to row 0 and enters CLR_ROW for the new row, using the attr of the triggering byte. There is no scroll.
- CLR_ROW: exactly COLS consecutive cycles of ram_ce=1, data {attr, 0x20}, addresses row*COLS .. row*COLS+COLS-1, then return to IDLE.
- CLR_ALL: ROWS*COLS writes (3000 by default) over addresses 0..2999 ascending, then return to IDLE.
- busy=1 and in_ready=0 throughout CLR_ROW and CLR_ALL.
- ram_ce=0 on every cycle with no write.
- cur_set:
  - Honoured only in IDLE.
  - In-range values load the cursor next cycle.
  - If cur_x_in≥COLS or cur_y_in≥ROWS, the cursor is unchanged.
  - cur_set is ignored while busy.
  - If cur_set and in_valid occur in the same cycle, cur_set wins and the byte stalls (ready low).
- Address arithmetic: row*COLS computed as a registered constant multiply or shift-add; ADDR_W bits; no overflow for default parameters.
- Reset mid-clear: aborts immediately to reset values. Partially cleared RAM is left as is; CLEAR_ON_RESET then restarts the clear from address 0.

Decomposition:
- Shared package (text display), used by this block and the LCD display:
  - COLS, ROWS, FONT_W=8, FONT_H=16.
  - Control-code constants CH_BS, CH_TAB, CH_LF, CH_CR, CH_FF, CH_SPACE.
  - Cell field positions ATTR_HI/LO, CHAR_HI/LO.
  - State enum.
- One natural sub-module: console_cursor. Holds cursor x/y, implements advance/wrap/tab/BS/set, and outputs the linear cell address.
- The FSM and RAM write register stay in the top module.

Test Plan:
- Reset with CLEAR_ON_RESET=1 → 3000 consecutive ram_ce pulses, addr 0..2999, data 0x0F20; then in_ready=1, cursor (0,0).
- Send 'A' with attr 0x1E at (0,0) → exactly one cycle later ram_ce=1, addr 0, data 0x1E41; cursor (1,0).
- cur_set (99,5), then send 'Z' → write at addr 599; cursor (0,6). Then CR, LF, BS → cursor (0,7), no ram_ce.
- cur_set (98,29), then TAB → cursor wraps to row 0; CLR_ROW writes addr 0..99 with 100 strobes; in_ready=0 for those 100 cycles.
- FF with attr 0x70 mid-stream → 3000 writes of 0x7020, busy high; in_valid held high is not accepted until the clear ends; cursor (0,0).
- Assert reset during CLR_ALL at addr 1500 → ram_ce=0 immediately; after release the clear restarts at addr 0. Also cur_set (120,3) → cursor unchanged.

Source files
------------

// File: rtl/text_console_writer_pkg.sv
// Shared text display definitions: screen geometry, control codes,
// RAM cell layout and the writer state encoding.
package text_console_writer_pkg;

    // Screen geometry (800x480 panel, 8x16 glyphs)
    localparam int TEXT_COLS = 100;
    localparam int TEXT_ROWS = 30;
    localparam int FONT_W    = 8;
    localparam int FONT_H    = 16;

    // Control codes understood by the writer
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_DEL   = 8'h7F;

    // Text RAM cell layout: {attr, char}
    localparam int ATTR_HI = 15;
    localparam int ATTR_LO = 8;
    localparam int CHAR_HI = 7;
    localparam int CHAR_LO = 0;

    // Writer FSM states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_CLR_ROW = 2'd1;
    localparam state_t ST_CLR_ALL = 2'd2;

    // Bytes that produce a glyph: 0x20..0x7E and the whole upper half
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CH_SPACE) && (c != CH_DEL);
    endfunction

endpackage

// File: rtl/text_console_writer_cursor.sv
// Hardware text cursor: column/row registers, advance, wrap, tab, backspace,
// direct load and home, plus the linear cell address of the cursor.
module console_cursor
    import text_console_writer_pkg::*;
#(
    parameter int COLS   = TEXT_COLS,
    parameter int ROWS   = TEXT_ROWS,
    parameter int ADDR_W = 12,
    parameter int TAB_W  = 8
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              adv,
    input  logic              cr,
    input  logic              lf,
    input  logic              bs,
    input  logic              tab,
    input  logic              set,
    input  logic              home,
    input  logic [6:0]        set_x,
    input  logic [4:0]        set_y,
    output logic [6:0]        x,
    output logic [4:0]        y,
    output logic [ADDR_W-1:0] cell_addr,
    output logic              row_wrap
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [7:0] TAB_STEP = 8'(TAB_W);
    localparam logic [7:0] COLS_8   = 8'(COLS);

    logic [6:0]        nx;
    logic [4:0]        ny;
    logic              inc_row;
    logic [7:0]        tab_next;
    logic [ADDR_W-1:0] row_base;

    // Next cursor position for whichever single operation is requested
    always_comb begin
        nx       = x;
        ny       = y;
        inc_row  = 1'b0;
        row_wrap = 1'b0;
        tab_next = (({1'b0, x} / TAB_STEP) + 8'd1) * TAB_STEP;
        if (home) begin
            nx = '0;
            ny = '0;
        end else if (set) begin
            if ((set_x <= LAST_COL) && (set_y <= LAST_ROW)) begin
                nx = set_x;
                ny = set_y;
            end
        end else if (adv) begin
            if (x == LAST_COL) begin
                nx      = '0;
                inc_row = 1'b1;
            end else begin
                nx = x + 7'd1;
            end
        end else if (cr) begin
            nx = '0;
        end else if (lf) begin
            inc_row = 1'b1;
        end else if (bs) begin
            if (x != 7'd0) begin
                nx = x - 7'd1;
            end
        end else if (tab) begin
            if (tab_next >= COLS_8) begin
                nx      = '0;
                inc_row = 1'b1;
            end else begin
                nx = tab_next[6:0];
            end
        end
        if (inc_row) begin
            if (y == LAST_ROW) begin
                ny       = '0;
                row_wrap = 1'b1;
            end else begin
                ny = y + 5'd1;
            end
        end
    end

    // Cursor registers; the row base address is kept registered alongside the row
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
        end else begin
            x        <= nx;
            y        <= ny;
            row_base <= ADDR_W'(ny) * ADDR_W'(COLS);
        end
    end

    assign cell_addr = row_base + ADDR_W'(x);

endmodule

// File: rtl/text_console_writer.sv
// Text console writer: turns a byte stream into {attr, char} writes on the
// text RAM port, with control codes, wrap, row clear and screen clear.
module text_console_writer
    import text_console_writer_pkg::*;
#(
    parameter int COLS           = TEXT_COLS,
    parameter int ROWS           = TEXT_ROWS,
    parameter int ADDR_W         = 12,
    parameter int TAB_W          = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_char,
    input  logic [7:0]        in_attr,
    input  logic              cur_set,
    input  logic [6:0]        cur_x_in,
    input  logic [4:0]        cur_y_in,
    output logic [6:0]        cursor_x,
    output logic [4:0]        cursor_y,
    output logic              busy,
    output logic              ram_ce,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_data
);

    localparam logic [ADDR_W-1:0] LAST_CELL     = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_CELL = ADDR_W'(COLS - 1);
    localparam logic [7:0]        RESET_ATTR    = 8'h0F;

    state_t            state;
    logic              started;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] clr_end;
    logic [7:0]        clr_attr;

    logic              accept;
    logic              printable;
    logic              do_set;
    logic              clr_done;
    logic              row_wrap;
    logic [ADDR_W-1:0] cell_addr;

    assign busy      = (state != ST_IDLE);
    assign in_ready  = started && (state == ST_IDLE) && !cur_set;
    assign accept    = in_valid && in_ready;
    assign printable = is_printable(in_char);
    assign do_set    = started && (state == ST_IDLE) && cur_set;
    assign clr_done  = (clr_addr == clr_end);

    console_cursor #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W),
        .TAB_W  (TAB_W)
    ) u_cursor (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .adv       (accept && printable),
        .cr        (accept && (in_char == CH_CR)),
        .lf        (accept && (in_char == CH_LF)),
        .bs        (accept && (in_char == CH_BS)),
        .tab       (accept && (in_char == CH_TAB)),
        .set       (do_set),
        .home      ((state == ST_CLR_ALL) && clr_done),
        .set_x     (cur_x_in),
        .set_y     (cur_y_in),
        .x         (cursor_x),
        .y         (cursor_y),
        .cell_addr (cell_addr),
        .row_wrap  (row_wrap)
    );

    // Writer FSM and registered RAM write port; the first cycle out of reset
    // optionally launches the full-screen clear
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            started  <= 1'b0;
            clr_addr <= '0;
            clr_end  <= '0;
            clr_attr <= '0;
            ram_ce   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
        end else begin
            ram_ce <= 1'b0;
            if (!started) begin
                started <= 1'b1;
                if (CLEAR_ON_RESET) begin
                    state    <= ST_CLR_ALL;
                    clr_addr <= '0;
                    clr_end  <= LAST_CELL;
                    clr_attr <= RESET_ATTR;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            if (printable) begin
                                ram_ce   <= 1'b1;
                                ram_addr <= cell_addr;
                                ram_data <= {in_attr, in_char};
                            end
                            if (in_char == CH_FF) begin
                                state    <= ST_CLR_ALL;
                                clr_addr <= '0;
                                clr_end  <= LAST_CELL;
                                clr_attr <= in_attr;
                            end else if (row_wrap) begin
                                // A row overflow always lands on row 0, whose base is 0
                                state    <= ST_CLR_ROW;
                                clr_addr <= '0;
                                clr_end  <= LAST_ROW_CELL;
                                clr_attr <= in_attr;
                            end
                        end
                    end
                    ST_CLR_ROW, ST_CLR_ALL: begin
                        ram_ce   <= 1'b1;
                        ram_addr <= clr_addr;
                        ram_data <= {clr_attr, CH_SPACE};
                        if (clr_done) begin
                            state <= ST_IDLE;
                        end else begin
                            clr_addr <= clr_addr + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer (default parameters).
module tb_text_console_writer;

    logic        clk_sys;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic [7:0]  in_attr;
    logic        cur_set;
    logic [6:0]  cur_x_in;
    logic [4:0]  cur_y_in;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;
    logic        ram_ce;
    logic [11:0] ram_addr;
    logic [15:0] ram_data;

    int vectors;
    int miscompares;

    text_console_writer dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_char  (in_char),
        .in_attr  (in_attr),
        .cur_set  (cur_set),
        .cur_x_in (cur_x_in),
        .cur_y_in (cur_y_in),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .busy     (busy),
        .ram_ce   (ram_ce),
        .ram_addr (ram_addr),
        .ram_data (ram_data)
    );

    // 100 MHz system clock
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic drive_byte(input logic [7:0] c, input logic [7:0] a);
        in_valid = 1'b1;
        in_char  = c;
        in_attr  = a;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic set_cursor(input logic [6:0] cx, input logic [4:0] cy);
        cur_set  = 1'b1;
        cur_x_in = cx;
        cur_y_in = cy;
        tick();
        cur_set  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        vectors++; if (ram_ce !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ram_ce: got %0h expected 0", ram_ce); end
        vectors++; if (ram_addr !== 12'd0) begin miscompares++; $display("[TB] FAIL rst_ram_addr: got %0h expected 0", ram_addr); end
        vectors++; if (ram_data !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_ram_data: got %0h expected 0", ram_data); end
        vectors++; if ({cursor_x, cursor_y} !== 12'd0) begin miscompares++; $display("[TB] FAIL rst_cursor: got (%0d,%0d) expected (0,0)", cursor_x, cursor_y); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_in_ready: got %0h expected 0", in_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %0h expected 0", busy); end
        reset = 1'b1;
    endtask

    task automatic test_power_on_clear();
        int k;
        logic ok;
        int bad_i;
        logic [11:0] bad_addr;
        logic [15:0] bad_data;
        logic bad_ce;
        k = 0;
        while (ram_ce !== 1'b1 && k < 8) begin tick(); k++; end
        vectors++; if (ram_ce !== 1'b1) begin miscompares++; $display("[TB] FAIL por_clear_start: got ram_ce %0h expected 1 within 8 cycles", ram_ce); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL por_busy: got %0h expected 1", busy); end
        ok = 1'b1; bad_i = 0; bad_addr = '0; bad_data = '0; bad_ce = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (ok && (ram_ce !== 1'b1 || ram_addr !== 12'(i) || ram_data !== 16'h0F20)) begin
                ok = 1'b0; bad_i = i; bad_addr = ram_addr; bad_data = ram_data; bad_ce = ram_ce;
            end
            tick();
        end
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL por_clear_seq: at write %0d got ce=%0h addr=%0d data=%0h expected ce=1 addr=%0d data=0f20", bad_i, bad_ce, bad_addr, bad_data, bad_i); end
        vectors++; if (ram_ce !== 1'b0) begin miscompares++; $display("[TB] FAIL por_clear_end: got ram_ce %0h expected 0 after 3000 writes", ram_ce); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL por_ready: got %0h expected 1", in_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL por_busy_end: got %0h expected 0", busy); end
        vectors++; if ({cursor_x, cursor_y} !== 12'd0) begin miscompares++; $display("[TB] FAIL por_cursor: got (%0d,%0d) expected (0,0)", cursor_x, cursor_y); end
    endtask

    task automatic test_print();
        drive_byte(8'h41, 8'h1E);
        vectors++; if (ram_ce !== 1'b1) begin miscompares++; $display("[TB] FAIL print_ce: got %0h expected 1", ram_ce); end
        vectors++; if (ram_addr !== 12'd0) begin miscompares++; $display("[TB] FAIL print_addr: got %0d expected 0", ram_addr); end
        vectors++; if (ram_data !== 16'h1E41) begin miscompares++; $display("[TB] FAIL print_data: got %0h expected 1e41", ram_data); end
        vectors++; if (cursor_x !== 7'd1 || cursor_y !== 5'd0) begin miscompares++; $display("[TB] FAIL print_cursor: got (%0d,%0d) expected (1,0)", cursor_x, cursor_y); end
        tick();
        vectors++; if (ram_ce !== 1'b0) begin miscompares++; $display("[TB] FAIL print_single: got ram_ce %0h expected 0", ram_ce); end
    endtask

    task automatic test_cursor_codes();
        // cur_set and a byte in the same cycle: cursor load wins, byte stalls
        in_valid = 1'b1; in_char = 8'h51; in_attr = 8'h1E;
        cur_set = 1'b1; cur_x_in = 7'd99; cur_y_in = 5'd5;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL set_stall_ready: got %0h expected 0", in_ready); end
        tick();
        cur_set = 1'b0; in_valid = 1'b0;
        vectors++; if (cursor_x !== 7'd99 || cursor_y !== 5'd5) begin miscompares++; $display("[TB] FAIL set_cursor: got (%0d,%0d) expected (99,5)", cursor_x, cursor_y); end
        vectors++; if (ram_ce !== 1'b0) begin miscompares++; $display("[TB] FAIL set_no_write: got ram_ce %0h expected 0", ram_ce); end
        drive_byte(8'h5A, 8'h1E);
        vectors++; if (ram_ce !== 1'b1 || ram_addr !== 12'd599 || ram_data !== 16'h1E5A) begin miscompares++; $display("[TB] FAIL z_write: got ce=%0h addr=%0d data=%0h expected ce=1 addr=599 data=1e5a", ram_ce, ram_addr, ram_data); end
        vectors++; if (cursor_x !== 7'd0 || cursor_y !== 5'd6) begin miscompares++; $display("[TB] FAIL z_wrap: got (%0d,%0d) expected (0,6)", cursor_x, cursor_y); end
        drive_byte(8'h0D, 8'h1E);
        vectors++; if (ram_ce !== 1'b0 || cursor_x !== 7'd0 || cursor_y !== 5'd6) begin miscompares++; $display("[TB] FAIL cr: got ce=%0h (%0d,%0d) expected ce=0 (0,6)", ram_ce, cursor_x, cursor_y); end
        drive_byte(8'h0A, 8'h1E);
        vectors++; if (ram_ce !== 1'b0 || cursor_x !== 7'd0 || cursor_y !== 5'd7) begin miscompares++; $display("[TB] FAIL lf: got ce=%0h (%0d,%0d) expected ce=0 (0,7)", ram_ce, cursor_x, cursor_y); end
        drive_byte(8'h08, 8'h1E);
        vectors++; if (ram_ce !== 1'b0 || cursor_x !== 7'd0 || cursor_y !== 5'd7) begin miscompares++; $display("[TB] FAIL bs_col0: got ce=%0h (%0d,%0d) expected ce=0 (0,7)", ram_ce, cursor_x, cursor_y); end
        drive_byte(8'h09, 8'h1E);
        vectors++; if (ram_ce !== 1'b0 || cursor_x !== 7'd8 || cursor_y !== 5'd7) begin miscompares++; $display("[TB] FAIL tab: got ce=%0h (%0d,%0d) expected ce=0 (8,7)", ram_ce, cursor_x, cursor_y); end
        drive_byte(8'h08, 8'h1E);
        vectors++; if (cursor_x !== 7'd7 || cursor_y !== 5'd7) begin miscompares++; $display("[TB] FAIL bs: got (%0d,%0d) expected (7,7)", cursor_x, cursor_y); end
        drive_byte(8'h7F, 8'h1E);
        vectors++; if (ram_ce !== 1'b0 || cursor_x !== 7'd7) begin miscompares++; $display("[TB] FAIL del_ignored: got ce=%0h x=%0d expected ce=0 x=7", ram_ce, cursor_x); end
        drive_byte(8'h80, 8'h11);
        vectors++; if (ram_ce !== 1'b1 || ram_addr !== 12'd707 || ram_data !== 16'h1180) begin miscompares++; $display("[TB] FAIL hi_print: got ce=%0h addr=%0d data=%0h expected ce=1 addr=707 data=1180", ram_ce, ram_addr, ram_data); end
        drive_byte(8'h01, 8'h11);
        vectors++; if (ram_ce !== 1'b0 || cursor_x !== 7'd8 || cursor_y !== 5'd7) begin miscompares++; $display("[TB] FAIL ctl_ignored: got ce=%0h (%0d,%0d) expected ce=0 (8,7)", ram_ce, cursor_x, cursor_y); end
    endtask

    task automatic test_tab_row_clear();
        logic ok_rdy;
        logic ok_wr;
        int bad_i;
        set_cursor(7'd98, 5'd29);
        vectors++; if (cursor_x !== 7'd98 || cursor_y !== 5'd29) begin miscompares++; $display("[TB] FAIL set_98_29: got (%0d,%0d) expected (98,29)", cursor_x, cursor_y); end
        drive_byte(8'h09, 8'h2A);
        vectors++; if (cursor_x !== 7'd0 || cursor_y !== 5'd0 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL tab_wrap: got (%0d,%0d) busy=%0h expected (0,0) busy=1", cursor_x, cursor_y, busy); end
        ok_rdy = 1'b1; ok_wr = 1'b1; bad_i = 0;
        for (int i = 0; i < 100; i++) begin
            if (in_ready !== 1'b0) ok_rdy = 1'b0;
            tick();
            if (ok_wr && (ram_ce !== 1'b1 || ram_addr !== 12'(i) || ram_data !== 16'h2A20)) begin
                ok_wr = 1'b0; bad_i = i;
            end
        end
        vectors++; if (!ok_rdy) begin miscompares++; $display("[TB] FAIL row_clr_ready: got in_ready 1 expected 0 during row clear"); end
        vectors++; if (!ok_wr) begin miscompares++; $display("[TB] FAIL row_clr_seq: at write %0d got ce=%0h addr=%0d data=%0h expected ce=1 addr=%0d data=2a20", bad_i, ram_ce, ram_addr, ram_data, bad_i); end
        vectors++; if (in_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL row_clr_done: got ready=%0h busy=%0h expected ready=1 busy=0", in_ready, busy); end
        tick();
        vectors++; if (ram_ce !== 1'b0) begin miscompares++; $display("[TB] FAIL row_clr_count: got ram_ce %0h expected 0 after 100 writes", ram_ce); end
    endtask

    task automatic test_form_feed();
        logic ok_rdy;
        logic ok_wr;
        int bad_i;
        drive_byte(8'h42, 8'h1E);
        vectors++; if (ram_ce !== 1'b1 || ram_addr !== 12'd0 || ram_data !== 16'h1E42) begin miscompares++; $display("[TB] FAIL b_write: got ce=%0h addr=%0d data=%0h expected ce=1 addr=0 data=1e42", ram_ce, ram_addr, ram_data); end
        in_valid = 1'b1; in_char = 8'h0C; in_attr = 8'h70;
        tick();
        in_char = 8'h43; in_attr = 8'h4F;
        vectors++; if (ram_ce !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL ff_start: got ce=%0h busy=%0h expected ce=0 busy=1", ram_ce, busy); end
        ok_rdy = 1'b1; ok_wr = 1'b1; bad_i = 0;
        for (int i = 0; i < 3000; i++) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) ok_rdy = 1'b0;
            tick();
            if (ok_wr && (ram_ce !== 1'b1 || ram_addr !== 12'(i) || ram_data !== 16'h7020)) begin
                ok_wr = 1'b0; bad_i = i;
            end
        end
        vectors++; if (!ok_rdy) begin miscompares++; $display("[TB] FAIL ff_stall: got ready=1 or busy=0 during clear expected ready=0 busy=1"); end
        vectors++; if (!ok_wr) begin miscompares++; $display("[TB] FAIL ff_seq: at write %0d got ce=%0h addr=%0d data=%0h expected ce=1 addr=%0d data=7020", bad_i, ram_ce, ram_addr, ram_data, bad_i); end
        vectors++; if (cursor_x !== 7'd0 || cursor_y !== 5'd0 || in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ff_home: got (%0d,%0d) ready=%0h expected (0,0) ready=1", cursor_x, cursor_y, in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++; if (ram_ce !== 1'b1 || ram_addr !== 12'd0 || ram_data !== 16'h4F43) begin miscompares++; $display("[TB] FAIL ff_held_byte: got ce=%0h addr=%0d data=%0h expected ce=1 addr=0 data=4f43", ram_ce, ram_addr, ram_data); end
        vectors++; if (cursor_x !== 7'd1 || cursor_y !== 5'd0) begin miscompares++; $display("[TB] FAIL ff_after_cursor: got (%0d,%0d) expected (1,0)", cursor_x, cursor_y); end
    endtask

    task automatic test_reset_mid_clear();
        int k;
        drive_byte(8'h0C, 8'h70);
        k = 0;
        while (!(ram_ce === 1'b1 && ram_addr === 12'd1500) && k < 4000) begin tick(); k++; end
        vectors++; if (ram_addr !== 12'd1500) begin miscompares++; $display("[TB] FAIL mid_reach: got addr %0d expected 1500 within budget", ram_addr); end
        reset = 1'b0;
        #1;
        vectors++; if (ram_ce !== 1'b0 || ram_addr !== 12'd0 || ram_data !== 16'h0000) begin miscompares++; $display("[TB] FAIL mid_abort: got ce=%0h addr=%0d data=%0h expected ce=0 addr=0 data=0", ram_ce, ram_addr, ram_data); end
        vectors++; if (busy !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_abort_flags: got busy=%0h ready=%0h expected 0 0", busy, in_ready); end
        tick(); tick();
        reset = 1'b1;
        k = 0;
        while (ram_ce !== 1'b1 && k < 8) begin tick(); k++; end
        vectors++; if (ram_ce !== 1'b1 || ram_addr !== 12'd0 || ram_data !== 16'h0F20) begin miscompares++; $display("[TB] FAIL restart_clear: got ce=%0h addr=%0d data=%0h expected ce=1 addr=0 data=0f20", ram_ce, ram_addr, ram_data); end
        set_cursor(7'd10, 5'd10);
        vectors++; if (cursor_x !== 7'd0 || cursor_y !== 5'd0) begin miscompares++; $display("[TB] FAIL set_while_busy: got (%0d,%0d) expected (0,0)", cursor_x, cursor_y); end
        k = 0;
        while (in_ready !== 1'b1 && k < 3100) begin tick(); k++; end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL restart_done: got in_ready %0h expected 1 within budget", in_ready); end
        tick();
        set_cursor(7'd4, 5'd2);
        vectors++; if (cursor_x !== 7'd4 || cursor_y !== 5'd2) begin miscompares++; $display("[TB] FAIL set_4_2: got (%0d,%0d) expected (4,2)", cursor_x, cursor_y); end
        set_cursor(7'd120, 5'd3);
        vectors++; if (cursor_x !== 7'd4 || cursor_y !== 5'd2) begin miscompares++; $display("[TB] FAIL set_x_range: got (%0d,%0d) expected (4,2)", cursor_x, cursor_y); end
        set_cursor(7'd7, 5'd30);
        vectors++; if (cursor_x !== 7'd4 || cursor_y !== 5'd2) begin miscompares++; $display("[TB] FAIL set_y_range: got (%0d,%0d) expected (4,2)", cursor_x, cursor_y); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_char     = 8'h00;
        in_attr     = 8'h00;
        cur_set     = 1'b0;
        cur_x_in    = 7'd0;
        cur_y_in    = 5'd0;
        tick();
        test_reset();
        test_power_on_clear();
        test_print();
        test_cursor_codes();
        test_tab_row_clear();
        test_form_feed();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
